// File: rtl/q_reg_bank.sv
// q_reg_bank: bank of DEPTH registers, each WIDTH bits, with one modify port,
// two combinational read ports and registered carry/zero flags.
//
// Ports:
//   clk, rst       rising-edge clock, async active-high reset
//   q_en           operation enable (0 = every register holds)
//   mode           op select: HOLD LOAD SHL SHR INC DEC CLR ROL
//   wr_addr        register targeted by the operation
//   s, ser_in      load data, serial bit for SHL/SHR
//   rd_addr_a/b    read addresses (>= DEPTH reads as zero)
//   q_a, q_b       read data (pre-edge register contents)
//   carry, zero    registered flags from the last executed operation
module q_reg_bank #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_en,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  s,
  input  logic              ser_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  q_a,
  output logic [WIDTH-1:0]  q_b,
  output logic              carry,
  output logic              zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_INC  = 3'b100;
  localparam logic [2:0] M_DEC  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q;
  logic             carry_d;
  logic             zero_q;
  logic             zero_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             wr_hit;

  // Select the addressed register. wr_hit only rises when the address
  // matches a real register, so out-of-range writes become no-ops.
  always_comb begin
    cur    = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        cur    = regs_q[i];
        wr_hit = q_en;
      end
    end
  end

  // Operation result. HOLD and LOAD pass the old carry through.
  always_comb begin
    res   = cur;
    res_c = carry_q;
    unique case (mode)
      M_HOLD: res = cur;
      M_LOAD: res = s;
      M_SHL: begin
        res   = {cur[WIDTH-2:0], ser_in};
        res_c = cur[WIDTH-1];
      end
      M_SHR: begin
        res   = {ser_in, cur[WIDTH-1:1]};
        res_c = cur[0];
      end
      // Extra top bit carries out of all-ones.
      M_INC: {res_c, res} = {1'b0, cur} + (WIDTH+1)'(1);
      // Top bit becomes 1 only when cur was zero (borrow).
      M_DEC: {res_c, res} = {1'b0, cur} - (WIDTH+1)'(1);
      M_CLR: begin
        res   = '0;
        res_c = 1'b0;
      end
      M_ROL: begin
        res   = {cur[WIDTH-2:0], cur[WIDTH-1]};
        res_c = cur[WIDTH-1];
      end
      default: res = cur;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit && wr_addr == ADDR_W'(i)) begin
        regs_d[i] = res;
      end
    end
    carry_d = wr_hit ? res_c : carry_q;
    zero_d  = zero_q;
    if (wr_hit && mode != M_HOLD) begin
      zero_d = (res == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Combinational reads; unmatched addresses return zero.
  always_comb begin
    q_a = '0;
    q_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == ADDR_W'(i)) q_a = regs_q[i];
      if (rd_addr_b == ADDR_W'(i)) q_b = regs_q[i];
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_q_reg_bank.sv
// tb_q_reg_bank: scoreboard bench for q_reg_bank, two instances
// (W4/D3 and W8/D5) checked against a behavioural model.
module tb_q_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en_a;
  logic [2:0] mode_a;
  logic [1:0] wa_a;
  logic [3:0] s_a;
  logic       ser_a;
  logic [1:0] ra_a;
  logic [1:0] rb_a;
  logic [3:0] qa_a;
  logic [3:0] qb_a;
  logic       c_a;
  logic       z_a;

  logic       en_b;
  logic [2:0] mode_b;
  logic [2:0] wa_b;
  logic [7:0] s_b;
  logic       ser_b;
  logic [2:0] ra_b;
  logic [2:0] rb_b;
  logic [7:0] qa_b;
  logic [7:0] qb_b;
  logic       c_b;
  logic       z_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] qa;
    logic [7:0] qb;
    logic       c;
    logic       z;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [2:0] md;
    logic [2:0] wa;
    logic [7:0] sv;
    logic       si;
    logic [2:0] ra;
    logic [2:0] rb;
  } op_t;

  exp_t       sbq[$];
  logic [7:0] mreg[2][8];
  logic       mc[2];
  logic       mz[2];
  int         mw[2]  = '{4, 8};
  int         mdp[2] = '{3, 5};

  q_reg_bank #(.WIDTH(4), .DEPTH(3), .ADDR_W(2)) u_a (
    .clk(clk), .rst(rst), .q_en(en_a), .mode(mode_a),
    .wr_addr(wa_a), .s(s_a), .ser_in(ser_a),
    .rd_addr_a(ra_a), .rd_addr_b(rb_a),
    .q_a(qa_a), .q_b(qb_a), .carry(c_a), .zero(z_a)
  );

  q_reg_bank #(.WIDTH(8), .DEPTH(5), .ADDR_W(3)) u_b (
    .clk(clk), .rst(rst), .q_en(en_b), .mode(mode_b),
    .wr_addr(wa_b), .s(s_b), .ser_in(ser_b),
    .rd_addr_a(ra_b), .rd_addr_b(rb_b),
    .q_a(qa_b), .q_b(qb_b), .carry(c_b), .zero(z_b)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(bit en, int md, int wa, int sv,
                             bit si, int ra, int rb);
    op_t o;
    o.en = en;
    o.md = 3'(md);
    o.wa = 3'(wa);
    o.sv = 8'(sv);
    o.si = si;
    o.ra = 3'(ra);
    o.rb = 3'(rb);
    return o;
  endfunction

  function automatic logic [7:0] mread(int sel, logic [2:0] a);
    if (int'(a) < mdp[sel]) return mreg[sel][a];
    return 8'h00;
  endfunction

  function automatic exp_t observe(int sel);
    exp_t g;
    if (sel == 0) g = exp_t'{{4'h0, qa_a}, {4'h0, qb_a}, c_a, z_a};
    else          g = exp_t'{qa_b, qb_b, c_b, z_b};
    return g;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mreg[k][i] = 8'h00;
      mc[k] = 1'b0;
      mz[k] = 1'b0;
    end
  endtask

  task automatic model_op(int sel, op_t o);
    logic [7:0] r, nr, mask;
    logic       nc, msb;
    int         w;
    if (!o.en || int'(o.wa) >= mdp[sel]) return;
    w    = mw[sel];
    mask = 8'((1 << w) - 1);
    r    = mreg[sel][o.wa];
    msb  = r[w-1];
    nr   = r;
    nc   = mc[sel];
    case (o.md)
      3'd0: nr = r;
      3'd1: nr = o.sv & mask;
      3'd2: begin nr = ((r << 1) | 8'(o.si)) & mask; nc = msb; end
      3'd3: begin nr = (8'(o.si) << (w - 1)) | (r >> 1); nc = r[0]; end
      3'd4: begin nr = (r + 8'd1) & mask; nc = (r == mask); end
      3'd5: begin nr = (r - 8'd1) & mask; nc = (r == 8'h00); end
      3'd6: begin nr = 8'h00; nc = 1'b0; end
      default: begin nr = ((r << 1) | 8'(msb)) & mask; nc = msb; end
    endcase
    mreg[sel][o.wa] = nr;
    mc[sel] = nc;
    if (o.md != 3'd0) mz[sel] = (nr == 8'h00);
  endtask

  task automatic setup(int sel, op_t o);
    @(negedge clk);
    if (sel == 0) begin
      en_a = o.en; mode_a = o.md; wa_a = o.wa[1:0];
      s_a = o.sv[3:0]; ser_a = o.si;
      ra_a = o.ra[1:0]; rb_a = o.rb[1:0];
      en_b = 1'b0;
    end else begin
      en_b = o.en; mode_b = o.md; wa_b = o.wa;
      s_b = o.sv; ser_b = o.si;
      ra_b = o.ra; rb_b = o.rb;
      en_a = 1'b0;
    end
    model_op(sel, o);
    sbq.push_back(exp_t'{mread(sel, o.ra), mread(sel, o.rb),
                         mc[sel], mz[sel]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_t  ops[$];
    exp_t e, g;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({qa_a, qb_a, c_a, z_a, qa_b, qb_b, c_b, z_b} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0",
               {qa_a, qb_a, c_a, z_a, qa_b, qb_b, c_b, z_b});
    end
    @(negedge clk);
    rst = 1'b0;
    ops.push_back(mk(1, 1, 0, 'hF, 0, 1, 0));
    ops.push_back(mk(1, 4, 0, 0, 0, 1, 0));
    ops.push_back(mk(1, 1, 1, 'hA, 0, 1, 2));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_pre[%0d] got=%h exp=%h", i, g, e);
      end
    end
    @(negedge clk);
    en_a = 1'b1; mode_a = 3'd1; wa_a = 2'd2; s_a = 4'h7;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({qa_a, c_a, z_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", {qa_a, c_a, z_a});
    end
    tick();
    checks++;
    if ({qa_a, qb_a, c_a, z_a} !== 10'b0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=0", {qa_a, qb_a, c_a, z_a});
    end
    @(negedge clk);
    en_a = 1'b0;
    rst  = 1'b0;
    model_reset();
    ops.delete();
    ops.push_back(mk(1, 4, 1, 0, 0, 1, 2));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_post[%0d] got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_load_hold();
    op_t  ops[$];
    exp_t e, g;
    ops.push_back(mk(1, 1, 2, 5, 0, 2, 2));
    repeat (3) ops.push_back(mk(0, 1, 2, 'hF, 0, 2, 2));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_hold[%0d] got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if ({qa_a, qb_a} !== 8'h55) begin
      errors++;
      $display("FAIL load_hold_final got=%h exp=55", {qa_a, qb_a});
    end
  endtask

  task automatic test_wrap();
    op_t  ops[$];
    exp_t e, g;
    ops.push_back(mk(1, 1, 0, 'hF, 0, 0, 1));
    ops.push_back(mk(1, 4, 0, 0, 0, 0, 1));
    ops.push_back(mk(1, 5, 0, 0, 0, 0, 1));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wrap[%0d] got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if ({qa_a, c_a, z_a} !== {4'hF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_final got=%h exp=%h", {qa_a, c_a, z_a}, 6'h3E);
    end
  endtask

  task automatic test_shifts();
    op_t  ops[$];
    exp_t e, g;
    ops.push_back(mk(1, 1, 1, 9, 0, 1, 0));
    ops.push_back(mk(1, 2, 1, 0, 0, 1, 0));
    ops.push_back(mk(1, 3, 1, 0, 1, 1, 0));
    ops.push_back(mk(1, 7, 1, 0, 0, 1, 0));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL shifts[%0d] got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if ({qa_a, c_a} !== {4'h3, 1'b1}) begin
      errors++;
      $display("FAIL shifts_final got=%h exp=07", {qa_a, c_a});
    end
  endtask

  task automatic test_range();
    op_t        ops[$];
    exp_t       e, g;
    logic [7:0] old;
    ops.push_back(mk(1, 1, 1, 6, 0, 1, 3));
    ops.push_back(mk(1, 6, 0, 0, 0, 1, 0));
    ops.push_back(mk(1, 1, 3, 7, 0, 3, 1));
    ops.push_back(mk(1, 4, 3, 0, 0, 3, 1));
    foreach (ops[i]) begin
      setup(0, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL range[%0d] got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if ({qa_a, qb_a, c_a, z_a} !== {4'h0, 4'h6, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL range_final got=%h exp=019",
               {qa_a, qb_a, c_a, z_a});
    end
    old = mread(0, 3'd1);
    setup(0, mk(1, 4, 1, 0, 0, 1, 1));
    #1;
    checks++;
    if ({4'h0, qa_a} !== old) begin
      errors++;
      $display("FAIL no_bypass got=%h exp=%h", qa_a, old);
    end
    tick();
    e = sbq.pop_front();
    g = observe(0);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL inc_visible got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_wide();
    op_t  ops[$];
    exp_t e, g;
    ops.push_back(mk(1, 1, 4, 'hFF, 0, 4, 7));
    ops.push_back(mk(1, 4, 4, 0, 0, 4, 7));
    ops.push_back(mk(1, 1, 6, 'hAA, 0, 6, 4));
    ops.push_back(mk(1, 5, 5, 0, 0, 4, 5));
    ops.push_back(mk(1, 3, 4, 0, 1, 4, 0));
    foreach (ops[i]) begin
      setup(1, ops[i]);
      tick();
      e = sbq.pop_front();
      g = observe(1);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wide[%0d] got=%h exp=%h", i, g, e);
      end
      if (i == 1) begin
        checks++;
        if ({qa_b, c_b, z_b} !== {8'h00, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL wide_wrap got=%h exp=003", {qa_b, c_b, z_b});
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e, g;
    op_t  o;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        rst  = 1'b1;
        #2 rst = 1'b0;
        model_reset();
      end
      o = mk($urandom_range(0, 7) != 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      setup(1, o);
      tick();
      e = sbq.pop_front();
      g = observe(1);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random[%0d] got=%h exp=%h", i, g, e);
      end
    end
  endtask

  initial begin
    en_a = 0; mode_a = 0; wa_a = 0; s_a = 0; ser_a = 0;
    ra_a = 0; rb_a = 0;
    en_b = 0; mode_b = 0; wa_b = 0; s_b = 0; ser_b = 0;
    ra_b = 0; rb_b = 0;
    model_reset();
    test_reset();
    test_load_hold();
    test_wrap();
    test_shifts();
    test_range();
    test_wide();
    test_random();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
